// File: rtl/mul_div_unit.sv
// Iterative RV64M multiply/divide unit: one shift-add or restoring-divide step per cycle,
// followed by a sign-correction cycle. Division corner cases resolve without iterating.
module mul_div_unit #(
   parameter int DATA_W = 64,
   parameter int CNT_W  = 6
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [2:0]        funct3_i,
   input  logic [DATA_W-1:0] rs1_data_i,
   input  logic [DATA_W-1:0] rs2_data_i,
   input  logic [4:0]        rd_addr_i,
   input  logic              flush_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] result_o,
   output logic [4:0]        rd_addr_o
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [2:0]          funct3_q;
   logic [4:0]          rd_q;
   logic                sign_a_q, sign_b_q;
   logic [DATA_W-1:0]   op_q;
   logic [2*DATA_W-1:0] acc_q;
   logic [CNT_W-1:0]    cnt_q;

   function automatic logic [DATA_W-1:0] neg_w(input logic neg, input logic [DATA_W-1:0] v);
      return neg ? (~v + DATA_W'(1)) : v;
   endfunction

   function automatic logic [2*DATA_W-1:0] neg_2w(input logic neg, input logic [2*DATA_W-1:0] v);
      return neg ? (~v + (2*DATA_W)'(1)) : v;
   endfunction

   // Operand decode at start
   logic              is_div, signed_a, signed_b, sa, sb, div_zero, div_ovf, special;
   logic [DATA_W-1:0] abs_a, abs_b, special_res;

   always_comb begin
      is_div      = funct3_i[2];
      signed_a    = (funct3_i != 3'b011) && !(funct3_i[2] && funct3_i[0]);
      signed_b    = (funct3_i == 3'b000) || (funct3_i == 3'b001) ||
                    (funct3_i == 3'b100) || (funct3_i == 3'b110);
      sa          = signed_a & rs1_data_i[DATA_W-1];
      sb          = signed_b & rs2_data_i[DATA_W-1];
      abs_a       = neg_w(sa, rs1_data_i);
      abs_b       = neg_w(sb, rs2_data_i);
      div_zero    = is_div && (rs2_data_i == '0);
      div_ovf     = is_div && !funct3_i[0] && (rs2_data_i == '1) &&
                    (rs1_data_i == {1'b1, {(DATA_W-1){1'b0}}});
      special     = div_zero || div_ovf;
      special_res = rs1_data_i;
      if (div_zero && !funct3_i[1]) special_res = '1;
      else if (!div_zero && funct3_i[1]) special_res = '0;
   end

   // One iteration: acc holds {product_hi, multiplier} or {remainder, dividend/quotient}
   logic [DATA_W:0]     mul_sum, div_trial, div_diff;
   logic                div_ge;
   logic [2*DATA_W-1:0] step_acc;

   always_comb begin
      mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, op_q} : '0);
      div_trial = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
      div_diff  = div_trial - {1'b0, op_q};
      div_ge    = (div_trial >= {1'b0, op_q});
      if (funct3_q[2])
         step_acc = {(div_ge ? div_diff[DATA_W-1:0] : div_trial[DATA_W-1:0]),
                     acc_q[DATA_W-2:0], div_ge};
      else
         step_acc = {mul_sum, acc_q[DATA_W-1:1]};
   end

   // Sign correction and result select
   logic [2*DATA_W-1:0] prod_fix;
   logic [DATA_W-1:0]   fix_res;

   always_comb begin
      prod_fix = neg_2w(sign_a_q ^ sign_b_q, acc_q);
      case (funct3_q)
         3'b000:         fix_res = prod_fix[DATA_W-1:0];
         3'b100, 3'b101: fix_res = neg_w(sign_a_q ^ sign_b_q, acc_q[DATA_W-1:0]);
         3'b110, 3'b111: fix_res = neg_w(sign_a_q, acc_q[2*DATA_W-1:DATA_W]);
         default:        fix_res = prod_fix[2*DATA_W-1:DATA_W];
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_i) state_d = special ? S_DONE : S_CALC;
         S_CALC:  if (cnt_q == '0) state_d = S_FIX;
         S_FIX:   state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (flush_i) state_d = S_IDLE;
   end

   assign busy_o = (state_q != S_IDLE);
   assign done_o = (state_q == S_DONE);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= S_IDLE;
         funct3_q  <= '0;
         rd_q      <= '0;
         sign_a_q  <= 1'b0;
         sign_b_q  <= 1'b0;
         op_q      <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         result_o  <= '0;
         rd_addr_o <= '0;
      end else begin
         state_q <= state_d;
         if (!flush_i) begin
            case (state_q)
               S_IDLE: if (start_i) begin
                  funct3_q <= funct3_i;
                  rd_q     <= rd_addr_i;
                  sign_a_q <= sa;
                  sign_b_q <= sb;
                  op_q     <= is_div ? abs_b : abs_a;
                  acc_q    <= {{DATA_W{1'b0}}, (is_div ? abs_a : abs_b)};
                  cnt_q    <= CNT_W'(DATA_W-1);
                  if (special) begin
                     result_o  <= special_res;
                     rd_addr_o <= rd_addr_i;
                  end
               end
               S_CALC: begin
                  acc_q <= step_acc;
                  cnt_q <= cnt_q - CNT_W'(1);
               end
               S_FIX: begin
                  result_o  <= fix_res;
                  rd_addr_o <= rd_q;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit with hand-computed results and latencies.
module tb_mul_div_unit;
   localparam int W = 64;

   logic         clk = 1'b0;
   logic         rst_i = 1'b0;
   logic         start_i = 1'b0;
   logic         flush_i = 1'b0;
   logic [2:0]   funct3_i = '0;
   logic [W-1:0] rs1_data_i = '0;
   logic [W-1:0] rs2_data_i = '0;
   logic [4:0]   rd_addr_i = '0;
   logic         busy_o, done_o;
   logic [W-1:0] result_o;
   logic [4:0]   rd_addr_o;

   int vectors = 0;
   int miscompares = 0;

   mul_div_unit #(.DATA_W(W), .CNT_W(6)) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .funct3_i(funct3_i),
      .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .rd_addr_i(rd_addr_i),
      .flush_i(flush_i), .busy_o(busy_o), .done_o(done_o),
      .result_o(result_o), .rd_addr_o(rd_addr_o)
   );

   always #5 clk = ~clk;

   // Presents an op for one edge (E0), then scrambles the operand inputs.
   task automatic launch(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [4:0] rd);
      @(negedge clk);
      funct3_i = f; rs1_data_i = a; rs2_data_i = b; rd_addr_i = rd; start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      rs1_data_i = 64'hA5A5_5A5A_0F0F_F0F0;
      rs2_data_i = 64'h1234_5678_9ABC_DEF0;
      rd_addr_i = 5'd31;
      funct3_i = ~f;
   endtask

   // Called #1 after E0; counts edges until done_o and checks the completion.
   task automatic wait_done(input string name, input int exp_lat, input logic [W-1:0] exp_res,
                            input logic [4:0] exp_rd);
      int lat = 0;
      int busy_cnt = 0;
      while (!done_o && lat < 300) begin
         if (busy_o) busy_cnt++;
         @(posedge clk); #1;
         lat++;
      end
      vectors++;
      if (lat !== exp_lat) begin
         miscompares++;
         $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
      end
      vectors++;
      if (result_o !== exp_res) begin
         miscompares++;
         $display("FAIL %s result: got %h expected %h", name, result_o, exp_res);
      end
      vectors++;
      if (rd_addr_o !== exp_rd) begin
         miscompares++;
         $display("FAIL %s rd_addr: got %0d expected %0d", name, rd_addr_o, exp_rd);
      end
      vectors++;
      if ({busy_cnt, busy_o} !== {exp_lat, 1'b1}) begin
         miscompares++;
         $display("FAIL %s busy: got %0d cycles (busy at done %b) expected %0d (1)",
                  name, busy_cnt, busy_o, exp_lat);
      end
      @(posedge clk); #1;
      vectors++;
      if ({busy_o, done_o} !== 2'b00) begin
         miscompares++;
         $display("FAIL %s after_done busy/done: got %b%b expected 00", name, busy_o, done_o);
      end
   endtask

   task automatic run_op(input string name, input logic [2:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [4:0] rd, input int exp_lat,
                         input logic [W-1:0] exp_res);
      launch(f, a, b, rd);
      wait_done(name, exp_lat, exp_res, rd);
   endtask

   task automatic count_done(input int n, output int c);
      c = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (done_o) c++;
      end
   endtask

   task automatic check_outputs_zero(input string name);
      vectors++;
      if ({busy_o, done_o, result_o, rd_addr_o} !== '0) begin
         miscompares++;
         $display("FAIL %s: got busy=%b done=%b result=%h rd=%0d expected all 0",
                  name, busy_o, done_o, result_o, rd_addr_o);
      end
   endtask

   task automatic test_reset();
      #12;
      check_outputs_zero("reset_state");
      @(negedge clk);
      rst_i = 1'b1;
   endtask

   task automatic test_mul();
      run_op("mul_7_x_m3", 3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 65, 64'hFFFF_FFFF_FFFF_FFEB);
      run_op("mulhu", 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd6, 65, 64'd1);
      run_op("mulh", 3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7, 65, 64'd0);
      run_op("mulhsu", 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd8, 65, 64'hFFFF_FFFF_FFFF_FFFF);
   endtask

   task automatic test_div();
      run_op("div_m7_2", 3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd10, 65, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op("rem_m7_2", 3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd11, 65, 64'hFFFF_FFFF_FFFF_FFFF);
      run_op("divu_100_7", 3'b101, 64'd100, 64'd7, 5'd12, 65, 64'd14);
      run_op("remu_100_7", 3'b111, 64'd100, 64'd7, 5'd13, 65, 64'd2);
   endtask

   task automatic test_div_special();
      run_op("divu_by_0", 3'b101, 64'd1234, 64'd0, 5'd14, 0, 64'hFFFF_FFFF_FFFF_FFFF);
      run_op("rem_9_by_0", 3'b110, 64'd9, 64'd0, 5'd15, 0, 64'd9);
      run_op("div_ovf", 3'b100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd16, 0,
             64'h8000_0000_0000_0000);
      run_op("rem_ovf", 3'b110, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd17, 0, 64'd0);
   endtask

   task automatic test_restart_flush();
      int lat = 0;
      int busy_cnt = 0;
      int extra;
      launch(3'b000, 64'd3, 64'd4, 5'd9);
      while (!done_o && lat < 300) begin
         if (busy_o) busy_cnt++;
         if (lat == 9) begin
            funct3_i = 3'b101; rs1_data_i = 64'd50; rs2_data_i = 64'd5; rd_addr_i = 5'd1;
            start_i = 1'b1;
         end else begin
            start_i = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      start_i = 1'b0;
      vectors++;
      if ({lat, result_o, rd_addr_o} !== {32'd65, 64'd12, 5'd9}) begin
         miscompares++;
         $display("FAIL restart_ignored: got lat=%0d result=%h rd=%0d expected lat=65 result=c rd=9",
                  lat, result_o, rd_addr_o);
      end
      count_done(80, extra);
      vectors++;
      if (extra !== 0) begin
         miscompares++;
         $display("FAIL restart_single_done: got %0d extra done pulses expected 0", extra);
      end

      launch(3'b101, 64'd100, 64'd7, 5'd3);
      repeat (19) begin @(posedge clk); #1; end
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      vectors++;
      if ({busy_o, done_o, result_o, rd_addr_o} !== {1'b0, 1'b0, 64'd12, 5'd9}) begin
         miscompares++;
         $display("FAIL flush_state: got busy=%b done=%b result=%h rd=%0d expected 0 0 c 9",
                  busy_o, done_o, result_o, rd_addr_o);
      end

      // flush must win over start in IDLE
      start_i = 1'b1; flush_i = 1'b1; funct3_i = 3'b000;
      @(posedge clk); #1;
      start_i = 1'b0; flush_i = 1'b0;
      vectors++;
      if (busy_o !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_over_start: got busy=%b expected 0", busy_o);
      end
      count_done(80, extra);
      vectors++;
      if (extra !== 0) begin
         miscompares++;
         $display("FAIL flush_no_done: got %0d done pulses expected 0", extra);
      end
      run_op("after_flush_remu", 3'b111, 64'd100, 64'd7, 5'd4, 65, 64'd2);
   endtask

   task automatic test_reset_mid();
      launch(3'b101, 64'd1000, 64'd3, 5'd7);
      repeat (30) begin @(posedge clk); #1; end
      #2 rst_i = 1'b0;
      #1 check_outputs_zero("async_reset_mid_calc");
      @(negedge clk);
      rst_i = 1'b1;
      run_op("divu_10_3_after_reset", 3'b101, 64'd10, 64'd3, 5'd8, 65, 64'd3);
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_div_special();
      test_restart_flush();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative RV64M multiply/divide execution unit.
- Consumes the two source operands read from the 64-bit register file and the destination register index.
- Produces a 64-bit result plus destination index for the writeback path into the register file.
- The pipeline stalls on busy_o while an operation is in flight.

Parameters:
- DATA_W, 64, operand/result width in bits; DATA_W must be a power of 2 and at least 8.
- CNT_W, 6, iteration counter width, equal to log2(DATA_W).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- start_i  input  1  request; sampled only in IDLE.
- funct3_i  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_data_i  input  DATA_W  operand A (multiplicand/dividend).
- rs2_data_i  input  DATA_W  operand B (multiplier/divisor).
- rd_addr_i  input  5  destination register index.
- flush_i  input  1  synchronous abort.
- busy_o  output  1  high in every state except IDLE.
- done_o  output  1  one-cycle result-valid pulse.
- result_o  output  DATA_W  registered result; held until the next done_o.
- rd_addr_o  output  5  rd_addr_i captured at start; held with result_o.

Behaviour:
- Reset (rst_i=0, asynchronous): state=IDLE; busy_o=0, done_o=0, result_o=0, rd_addr_o=0; counter and internal registers cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start_i=1 at edge E0:
  - Latch funct3, rd_addr, and the operand signs.
  - Latch absolute values for signed ops: MUL/MULH/DIV/REM use both signs; MULHSU uses rs1 sign only; unsigned ops use raw values.
  - counter=DATA_W-1.
  - Next state is CALC, except for the special cases below, which go straight to DONE.
- Division special cases, resolved at E0 with no iterations:
  - Divisor 0: DIV/DIVU quotient = all ones; REM/REMU result = rs1.
  - Signed overflow (DIV/REM with rs1 = most negative value, rs2 = -1): DIV result = rs1; REM result = 0.
  - result_o loads at E0; done_o is high in the following cycle (1-cycle latency).
- CALC, one iteration per edge, E1..E64 for DATA_W=64:
  - Multiply: shift-add into a 2*DATA_W product register.
  - Divide: restoring divide, shift-subtract into quotient and remainder.
  - counter decrements each iteration; at counter==0 the next state is FIX.
- FIX (edge E65):
  - Apply two's-complement sign correction.
  - Product sign = XOR of the effective operand signs.
  - Quotient sign = XOR of the operand signs.
  - Remainder sign = dividend sign.
  - Select the result: MUL = low half; MULH/MULHSU/MULHU = high half; DIV/DIVU = quotient; REM/REMU = remainder.
  - Register result_o and rd_addr_o; next state is DONE.
- DONE: done_o=1 for exactly one cycle; next state is IDLE.
- Normal latency: done_o is high in the cycle after E65 (65 cycles after the start edge).
- busy_o is high from the cycle after E0 through the DONE cycle.
- start_i in CALC/FIX/DONE is ignored; no queueing.
- start_i is accepted again in the first IDLE cycle, i.e. the cycle after DONE.
- flush_i=1 at any edge:
  - Next state is IDLE; done_o=0.
  - result_o and rd_addr_o keep their previous values.
  - flush_i has priority over start_i in IDLE: nothing starts.
- Reset asserted mid-operation: immediate return to the reset values; no done_o.
- Operand inputs may change after E0 without affecting the result.

Test Plan:
- MUL 7 x -3 (rs1=7, rs2=0xFFFF_FFFF_FFFF_FFFD, rd=5) -> done_o exactly 65 cycles after start; result_o=0xFFFF_FFFF_FFFF_FFEB; rd_addr_o=5; busy_o high 65 cycles.
- MULHU 0xFFFF_FFFF_FFFF_FFFF x 2 -> result_o=1. MULH -1 x -1 -> result_o=0. MULHSU -1 x 2 -> result_o=0xFFFF_FFFF_FFFF_FFFF.
- DIV -7 / 2 -> result_o=-3; REM -7 / 2 -> result_o=-1; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2; each with 65-cycle latency.
- DIVU x / 0 -> all ones. REM 9 / 0 -> 9. DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000. REM of the same operands -> 0. All four return done_o the cycle after start.
- start_i pulsed again at cycle 10 of a MUL -> ignored, single done_o with the first result. flush_i at cycle 20 -> IDLE next cycle, busy_o=0, no done_o, result_o unchanged. A new start is then accepted immediately.
- rst_i low mid-CALC -> all outputs 0 asynchronously. After release, DIVU 10 / 3 completes with result_o=3.
